// File: rtl/usb_ep_pkg.sv
`default_nettype none
// ============================================================================
// Package  : usb_ep_pkg
// Purpose  : USB device descriptor type and the default endpoint configuration.
// Revision : 1.0
// ============================================================================
package usb_ep_pkg;

    typedef struct packed {
        logic [15:0] bcdUSB;
        logic [7:0]  bDeviceClass;
        logic [7:0]  bDeviceSubClass;
        logic [7:0]  bDeviceProtocol;
        logic [7:0]  bMaxPacketSize0;
        logic [15:0] idVendor;
        logic [15:0] idProduct;
        logic [15:0] bcdDevice;
        logic [7:0]  iManufacturer;
        logic [7:0]  iProduct;
        logic [7:0]  iSerialNumber;
        logic [7:0]  bNumConfigurations;
    } usb_device_desc_t;

    typedef struct packed {
        usb_device_desc_t deviceDesc;
    } usb_device_ep_config_t;

    localparam usb_device_ep_config_t DefaultUsbDeviceEpConfig = '{
        deviceDesc: '{
            bcdUSB:             16'h0200,
            bDeviceClass:       8'h2A,
            bDeviceSubClass:    8'h2A,
            bDeviceProtocol:    8'h2A,
            bMaxPacketSize0:    8'd8,
            idVendor:           16'h1D50,
            idProduct:          16'h6130,
            bcdDevice:          16'h0100,
            iManufacturer:      8'd1,
            iProduct:           8'd2,
            iSerialNumber:      8'd0,
            bNumConfigurations: 8'd1
        }
    };

endpackage
`default_nettype wire

// File: rtl/ep0_desc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ep0_desc_sequencer
// Purpose  : Streams the 18-byte device descriptor as EP0 IN packets of maxPkt.
// Revision : 1.0
// ============================================================================
module ep0_desc_sequencer #(
    parameter usb_ep_pkg::usb_device_desc_t DESC = usb_ep_pkg::DefaultUsbDeviceEpConfig.deviceDesc
) (
    input  logic        clk48,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] reqLength,
    input  logic        abort,
    input  logic        inToken,
    output logic        pktAvail,
    output logic        dataValid,
    output logic [7:0]  data,
    output logic        dataLast,
    input  logic        dataReady,
    input  logic        txAck,
    input  logic        txRetry,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] DESC_LEN      = 16'd18;
    localparam logic [7:0]  MAX_PKT       = DESC.bMaxPacketSize0;
    localparam bit          MAX_PKT_LEGAL = (MAX_PKT == 8'd8)  || (MAX_PKT == 8'd16) ||
                                            (MAX_PKT == 8'd32) || (MAX_PKT == 8'd64);

    localparam logic [7:0] IMAGE [0:17] = '{
        8'h12, 8'h01,
        DESC.bcdUSB[7:0], DESC.bcdUSB[15:8],
        DESC.bDeviceClass, DESC.bDeviceSubClass, DESC.bDeviceProtocol,
        DESC.bMaxPacketSize0,
        DESC.idVendor[7:0], DESC.idVendor[15:8],
        DESC.idProduct[7:0], DESC.idProduct[15:8],
        DESC.bcdDevice[7:0], DESC.bcdDevice[15:8],
        DESC.iManufacturer, DESC.iProduct, DESC.iSerialNumber,
        DESC.bNumConfigurations
    };

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_TOKEN = 2'd1,
        SEND       = 2'd2,
        WAIT_HS    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] total_q, total_d;
    logic [15:0] offset_q, offset_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        pktAvail_q, pktAvail_d;
    logic        dataValid_q, dataValid_d;
    logic [7:0]  data_q, data_d;
    logic        dataLast_q, dataLast_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] remain;

    always_comb begin
        state_d     = state_q;
        total_d     = total_q;
        offset_d    = offset_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        data_d      = 8'h00;
        dataLast_d  = 1'b0;
        remain      = total_q - offset_q;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        total_d  = (reqLength > DESC_LEN) ? DESC_LEN : reqLength;
                        offset_d = 16'd0;
                        if (total_d == 16'd0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = WAIT_TOKEN;
                        end
                    end
                end
                WAIT_TOKEN: begin
                    if (inToken) begin
                        cnt_d   = (remain > {8'd0, MAX_PKT}) ? MAX_PKT[6:0] : remain[6:0];
                        ptr_d   = offset_q[4:0];
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (dataReady) begin
                        if (dataLast_q) begin
                            state_d = WAIT_HS;
                        end else begin
                            ptr_d = ptr_q + 5'd1;
                        end
                    end
                end
                WAIT_HS: begin
                    // Ack takes priority over a simultaneous retry.
                    if (txAck) begin
                        offset_d = offset_q + {9'd0, cnt_q};
                        if (offset_d == total_q) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_TOKEN;
                        end
                    end else if (txRetry) begin
                        state_d = WAIT_TOKEN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        pktAvail_d  = (state_d == WAIT_TOKEN);
        dataValid_d = (state_d == SEND);
        busy_d      = (state_d != IDLE);
        if (state_d == SEND) begin
            data_d     = IMAGE[ptr_d];
            dataLast_d = ({11'd0, ptr_d} == (offset_d + {9'd0, cnt_d} - 16'd1));
        end
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            state_q     <= IDLE;
            total_q     <= 16'd0;
            offset_q    <= 16'd0;
            ptr_q       <= 5'd0;
            cnt_q       <= 7'd0;
            pktAvail_q  <= 1'b0;
            dataValid_q <= 1'b0;
            data_q      <= 8'h00;
            dataLast_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            offset_q    <= offset_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            pktAvail_q  <= pktAvail_d;
            dataValid_q <= dataValid_d;
            data_q      <= data_d;
            dataLast_q  <= dataLast_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pktAvail  = pktAvail_q;
    assign dataValid = dataValid_q;
    assign data      = data_q;
    assign dataLast  = dataLast_q;
    assign busy      = busy_q;
    assign done      = done_q;

    a_maxpkt_legal: assert property (@(posedge clk48) MAX_PKT_LEGAL);

endmodule
`default_nettype wire

// File: tb/tb_ep0_desc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ep0_desc_sequencer
// Purpose  : Scoreboard bench for the EP0 device-descriptor sequencer.
// Revision : 1.0
// ============================================================================
module tb_ep0_desc_sequencer;

    logic        clk48     = 1'b0;
    logic        rst       = 1'b1;
    logic        start     = 1'b0;
    logic [15:0] reqLength = 16'd0;
    logic        abort     = 1'b0;
    logic        inToken   = 1'b0;
    logic        dataReady = 1'b0;
    logic        txAck     = 1'b0;
    logic        txRetry   = 1'b0;
    logic        pktAvail, dataValid, dataLast, busy, done;
    logic [7:0]  data;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [8:0] exp_q [$];
    logic [7:0] img [0:17] = '{8'h12, 8'h01, 8'h00, 8'h02, 8'h2A, 8'h2A, 8'h2A, 8'h08,
                               8'h50, 8'h1D, 8'h30, 8'h61, 8'h00, 8'h01, 8'h01, 8'h02,
                               8'h00, 8'h01};

    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    always #5 clk48 = ~clk48;

    ep0_desc_sequencer dut (
        .clk48     (clk48),
        .rst       (rst),
        .start     (start),
        .reqLength (reqLength),
        .abort     (abort),
        .inToken   (inToken),
        .pktAvail  (pktAvail),
        .dataValid (dataValid),
        .data      (data),
        .dataLast  (dataLast),
        .dataReady (dataReady),
        .txAck     (txAck),
        .txRetry   (txRetry),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Byte monitor: pops the scoreboard on every accepted byte
    always @(negedge clk48) begin
        logic [8:0] e;
        if (done) done_cnt++;
        if (prev_hold) begin
            chk("hold_valid", {31'd0, dataValid}, 32'd1);
            chk("hold_data", {24'd0, data}, {24'd0, prev_data});
            chk("hold_last", {31'd0, dataLast}, {31'd0, prev_last});
        end
        if (dataValid && dataReady && !abort && !rst) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data", {24'd0, data}, {24'd0, e[7:0]});
                chk("dataLast", {31'd0, dataLast}, {31'd0, e[8]});
            end
        end
        prev_hold = dataValid && !dataReady && !abort && !rst;
        prev_data = data;
        prev_last = dataLast;
    end

    task automatic tick();
        @(posedge clk48);
        #1;
    endtask

    task automatic start_xfer(input logic [15:0] len);
        tick();
        start     = 1'b1;
        reqLength = len;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_pkt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (pktAvail) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("pktAvail_timeout", 32'd0, 32'd1);
    endtask

    task automatic get_packet(input int off, input int cnt, input bit toggle);
        bit ok;
        wait_pkt(ok);
        if (!ok) return;
        inToken = 1'b1;
        for (int i = 0; i < cnt; i++) exp_q.push_back({(i == cnt - 1), img[off + i]});
        dataReady = 1'b1;
        tick();
        inToken = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            if (toggle) dataReady = ~dataReady;
            tick();
        end
        if (!ok) begin
            chk("drain_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
        dataReady = 1'b1;
        chk("hs_dataValid", {31'd0, dataValid}, 32'd0);
        chk("hs_pktAvail", {31'd0, pktAvail}, 32'd0);
        chk("hs_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic send_hs(input bit ack, input bit retry, input bit exp_done);
        txAck   = ack;
        txRetry = retry;
        tick();
        txAck   = 1'b0;
        txRetry = 1'b0;
        chk("done_pulse", {31'd0, done}, {31'd0, exp_done});
        chk("busy_after_hs", {31'd0, busy}, {31'd0, !exp_done});
        chk("pktAvail_after_hs", {31'd0, pktAvail}, {31'd0, !exp_done});
    endtask

    task automatic run_xfer(input int len, input bit retry_first, input bit toggle, input bit both);
        int total, off, cnt, d0;
        total = (len > 18) ? 18 : len;
        d0    = done_cnt;
        off   = 0;
        start_xfer(len[15:0]);
        while (off < total) begin
            cnt = ((total - off) > 8) ? 8 : (total - off);
            get_packet(off, cnt, toggle);
            if (retry_first && off == 0) begin
                send_hs(1'b0, 1'b1, 1'b0);
                get_packet(off, cnt, toggle);
            end
            off += cnt;
            send_hs(1'b1, both, off == total);
        end
        tick();
        tick();
        chk("done_count", done_cnt - d0, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_pktAvail", {31'd0, pktAvail}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  d0;
        bit  ok;

        repeat (3) tick();
        chk("rst_pktAvail", {31'd0, pktAvail}, 32'd0);
        chk("rst_dataValid", {31'd0, dataValid}, 32'd0);
        chk("rst_dataLast", {31'd0, dataLast}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'd0);
        rst = 1'b0;
        tick();

        // Stray handshake inputs while idle
        inToken = 1'b1; txAck = 1'b1; txRetry = 1'b1;
        tick();
        inToken = 1'b0; txAck = 1'b0; txRetry = 1'b0;
        tick();
        chk("idle_ignore_busy", {31'd0, busy}, 32'd0);
        chk("idle_ignore_pktAvail", {31'd0, pktAvail}, 32'd0);
        chk("idle_ignore_dataValid", {31'd0, dataValid}, 32'd0);
        chk("idle_ignore_done", done_cnt, 32'd0);

        run_xfer(64, 1'b0, 1'b0, 1'b0);
        run_xfer(16, 1'b0, 1'b0, 1'b0);
        run_xfer(3,  1'b0, 1'b0, 1'b0);
        run_xfer(18, 1'b1, 1'b0, 1'b0);
        run_xfer(18, 1'b0, 1'b1, 1'b1);

        // Abort on the 4th byte of packet 2; a start while busy is ignored
        d0 = done_cnt;
        start_xfer(16'd18);
        start = 1'b1; reqLength = 16'd3;
        tick();
        start = 1'b0;
        get_packet(0, 8, 1'b0);
        send_hs(1'b1, 1'b0, 1'b0);
        wait_pkt(ok);
        inToken = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, img[8 + i]});
        dataReady = 1'b1;
        tick();
        inToken = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("abort_byte4_valid", {31'd0, dataValid}, 32'd1);
        chk("abort_byte4_data", {24'd0, data}, {24'd0, img[11]});
        dataReady = 1'b0;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_dataValid", {31'd0, dataValid}, 32'd0);
        chk("abort_pktAvail", {31'd0, pktAvail}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        tick();
        tick();
        chk("abort_no_done", done_cnt - d0, 32'd0);
        dataReady = 1'b1;
        run_xfer(18, 1'b0, 1'b0, 1'b0);

        // Zero-length request
        d0 = done_cnt;
        tick();
        start = 1'b1; reqLength = 16'd0;
        tick();
        start = 1'b0;
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("zero_pktAvail", {31'd0, pktAvail}, 32'd0);
        end
        chk("zero_done_count", done_cnt - d0, 32'd1);

        // Reset while waiting for the handshake, then immediate restart
        d0 = done_cnt;
        start_xfer(16'd18);
        get_packet(0, 8, 1'b0);
        rst = 1'b1;
        tick();
        chk("rsths_pktAvail", {31'd0, pktAvail}, 32'd0);
        chk("rsths_dataValid", {31'd0, dataValid}, 32'd0);
        chk("rsths_dataLast", {31'd0, dataLast}, 32'd0);
        chk("rsths_busy", {31'd0, busy}, 32'd0);
        chk("rsths_done", {31'd0, done}, 32'd0);
        chk("rsths_data", {24'd0, data}, 32'd0);
        rst   = 1'b0;
        start = 1'b1; reqLength = 16'd3;
        tick();
        start = 1'b0;
        chk("post_rst_busy", {31'd0, busy}, 32'd1);
        chk("post_rst_pktAvail", {31'd0, pktAvail}, 32'd1);
        get_packet(0, 3, 1'b0);
        send_hs(1'b1, 1'b0, 1'b1);
        tick();
        tick();
        chk("post_rst_done_count", done_cnt - d0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ep0_desc_sequencer.md
EP0_DESC_SEQUENCER -- requirements
Module: ep0_desc_sequencer

Interface
REQ-001 SHALL have parameter DESC, default usb_ep_pkg::DefaultUsbDeviceEpConfig.deviceDesc; device descriptor served by the block.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk48 in 1, rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 start  in  1  pulse; begin GET_DESCRIPTOR(Device) data stage.
REQ-005 reqLength  in  16  wLength from SETUP; sampled when start is accepted.
REQ-006 abort  in  1  SETUP or bus reset seen; cancel the transfer.
REQ-007 inToken  in  1  pulse; host IN token addressed to EP0.
REQ-008 pktAvail  out  1  a data packet is ready for the next IN token.
REQ-009 dataValid  out  1  data byte valid.
REQ-010 data  out  8  descriptor byte.
REQ-011 dataLast  out  1  data is the final byte of the current packet.
REQ-012 dataReady  in  1  consumer accepts the byte when dataValid is high in the same cycle.
REQ-013 txAck  in  1  pulse; host ACKed the last packet.
REQ-014 txRetry  in  1  pulse; handshake timeout; resend the same packet.
REQ-015 busy  out  1  transfer in progress (state != IDLE).
REQ-016 done  out  1  one-cycle pulse; data stage completed successfully.

Function
REQ-017 Descriptor image SHALL be 18 bytes, little-endian, in this order: 0x12, 0x01, bcdUSB[7:0], bcdUSB[15:8], bDeviceClass, bDeviceSubClass, bDeviceProtocol, bMaxPacketSize0, idVendor lo/hi, idProduct lo/hi, bcdDevice lo/hi, iManufact, iProduct, iSerialNumber, bNumConfigurations.
REQ-018 maxPkt SHALL be the numeric value of DESC.bMaxPacketSize0; only 8/16/32/64 are legal (simulation assertion otherwise).
REQ-019 SHALL implement states IDLE, WAIT_TOKEN, SEND, WAIT_HS.
REQ-020 IDLE + start: total = min(reqLength, 18) computed at 16-bit width, offset = 0.
- total == 0: done pulses in the next cycle and the block remains in IDLE.
- otherwise: go to WAIT_TOKEN.
REQ-021 WAIT_TOKEN: pktAvail = 1. On inToken: cnt = min(maxPkt, total - offset), ptr = offset, go to SEND.
REQ-022 SEND: dataValid = 1 and data = image[ptr] (registered, no combinational path from dataReady to data).
- dataLast = (ptr == offset + cnt - 1).
- Each accepted byte increments ptr.
- Acceptance of the last byte moves to WAIT_HS.
- dataReady low holds data, ptr and dataLast stable.
REQ-023 WAIT_HS, txAck:
- offset += cnt.
- If the new offset == total: done pulse, go to IDLE.
- Otherwise: go to WAIT_TOKEN.
REQ-024 WAIT_HS, txRetry: offset unchanged, go to WAIT_TOKEN; the resent packet SHALL be byte-identical.
REQ-025 txAck and txRetry in the same cycle: txAck wins.
REQ-026 abort in any state: go to IDLE next cycle, no done pulse; abort outranks start, inToken, txAck and txRetry.
REQ-027 Ignored inputs: start while busy; inToken outside WAIT_TOKEN; txAck/txRetry outside WAIT_HS.
REQ-028 Because 18 is not a multiple of any legal maxPkt, no zero-length packet SHALL ever be generated; the transfer ends when offset == total.
REQ-029 pktAvail, dataValid and busy SHALL be registered outputs.

Reset
REQ-030 rst SHALL force IDLE; pktAvail, dataValid, dataLast, busy and done = 0; data = 0x00; offset, ptr, cnt and total = 0.
REQ-031 rst mid-transfer SHALL behave as abort (no done); start is honoured the cycle after rst deasserts.

Verification (DESC = default, maxPkt = 8)
REQ-032 reqLength = 64, ACK every packet -> packets of 8, 8, 2 bytes; first packet 12 01 00 02 2A 2A 2A 08; last packet 00 01; done pulses once after the third ACK.
REQ-033 reqLength = 16 -> two 8-byte packets, done after the second ACK, pktAvail stays 0 afterwards; reqLength = 3 -> single packet 12 01 00.
REQ-034 reqLength = 18, txRetry after the first packet -> next inToken yields an identical 8 bytes; total bytes ACKed = 18; one done.
REQ-035 dataReady toggled 1/0 every cycle during SEND -> no byte lost or duplicated; data stable while dataReady = 0.
REQ-036 abort asserted on the 4th byte of packet 2 -> busy = 0 next cycle, no done; a new start with reqLength = 18 completes normally.
REQ-037 reqLength = 0 -> done one cycle after start, pktAvail never asserts; rst asserted in WAIT_HS -> all outputs 0 next cycle.
